// File: rtl/nn_pkg.sv
// -----------------------------------------------------------------------------
// nn_pkg
// Shared constants and state encoding for the digit-recognition datapath.
// Used by the image frame buffer, the NN inference core and the benches.
//   PIX_W     pixel width (raw 0..255; normalisation happens in the core)
//   IMG_SIZE  pixels per 28x28 frame
//   ADDR_W    pixel address width (2**ADDR_W >= IMG_SIZE)
//   CNT_W     completed-frame counter width
// -----------------------------------------------------------------------------
package nn_pkg;

  localparam int PIX_W    = 8;
  localparam int IMG_SIZE = 784;
  localparam int ADDR_W   = 10;
  localparam int CNT_W    = 16;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_SIZE - 1);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } fb_state_e;

endpackage

// File: rtl/img_frame_buffer_if.sv
// -----------------------------------------------------------------------------
// img_frame_buffer_if
// Bundles the pixel stream, the image read port and the frame status
// signals between the upstream source, the frame buffer and the NN core.
//   slave  : frame buffer side (consumes stream, serves reads)
//   master : environment side (produces stream, issues reads)
// -----------------------------------------------------------------------------
interface img_frame_buffer_if;
  import nn_pkg::*;

  logic              s_valid;
  logic              s_ready;
  logic [PIX_W-1:0]  s_data;
  logic              s_last;
  logic              frame_ready;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [PIX_W-1:0]  rd_data;
  logic              rd_valid;
  logic              frame_done;
  logic              err_len;
  logic [CNT_W-1:0]  frame_cnt;

  modport slave (
    input  s_valid, s_data, s_last, rd_en, rd_addr, frame_done,
    output s_ready, frame_ready, rd_data, rd_valid, err_len, frame_cnt
  );

  modport master (
    output s_valid, s_data, s_last, rd_en, rd_addr, frame_done,
    input  s_ready, frame_ready, rd_data, rd_valid, err_len, frame_cnt
  );

endinterface

// File: rtl/img_ram.sv
// -----------------------------------------------------------------------------
// img_ram
// Simple dual-port synchronous RAM holding one image, registered read.
//   clk_i    clock
//   rst_n_i  async active-low reset (read register only; array is not reset)
//   we_i, waddr_i, wdata_i  write port
//   re_i, raddr_i           read request; rdata_o valid the next cycle
//   rdata_o  read data; addresses beyond the image return 0, holds when idle
// -----------------------------------------------------------------------------
module img_ram
  import nn_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [PIX_W-1:0]  wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [PIX_W-1:0]  rdata_o
);

  logic [PIX_W-1:0] mem [IMG_SIZE];
  logic [PIX_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= (raddr_i <= LAST_ADDR) ? mem[raddr_i] : '0;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/img_frame_buffer.sv
// -----------------------------------------------------------------------------
// img_frame_buffer
// Collects one 28x28 frame from a valid/ready pixel stream, checks its length
// and holds it as a read-only image memory for the NN core until released.
//   CLK    system clock, rising edge
//   RST_N  async active-low reset
//   bus    img_frame_buffer_if.slave: s_valid/s_ready/s_data/s_last stream,
//          rd_en/rd_addr -> rd_data/rd_valid (1-cycle latency),
//          frame_ready, frame_done, err_len pulse, frame_cnt
// -----------------------------------------------------------------------------
module img_frame_buffer
  import nn_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  img_frame_buffer_if.slave bus
);

  fb_state_e         state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic              s_ready_q, s_ready_d;
  logic              frame_ready_q, frame_ready_d;
  logic              err_len_q, err_len_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic              rd_valid_q, rd_valid_d;
  logic              accept;
  logic              rd_req;

  // s_ready_q is only ever high in FILL, so it doubles as the state qualifier.
  assign accept = bus.s_valid && s_ready_q;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    err_len_d   = 1'b0;
    frame_cnt_d = frame_cnt_q;
    rd_req      = 1'b0;

    case (state_q)
      FILL: begin
        if (accept) begin
          if (wr_ptr_q == LAST_ADDR) begin
            wr_ptr_d = '0;
            if (bus.s_last) begin
              state_d     = FULL;
              frame_cnt_d = frame_cnt_q + CNT_W'(1);
            end else begin
              // Long frame: drop it, next pixel starts a fresh frame.
              err_len_d = 1'b1;
            end
          end else if (bus.s_last) begin
            wr_ptr_d  = '0;
            err_len_d = 1'b1;
          end else begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          end
        end
      end
      FULL: begin
        // A read issued together with frame_done is still serviced.
        rd_req = bus.rd_en;
        if (bus.frame_done) begin
          state_d = FILL;
        end
      end
      default: ;
    endcase

    s_ready_d     = (state_d == FILL);
    frame_ready_d = (state_d == FULL);
    rd_valid_d    = rd_req;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= FILL;
      wr_ptr_q      <= '0;
      s_ready_q     <= 1'b0;
      frame_ready_q <= 1'b0;
      err_len_q     <= 1'b0;
      frame_cnt_q   <= '0;
      rd_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      s_ready_q     <= s_ready_d;
      frame_ready_q <= frame_ready_d;
      err_len_q     <= err_len_d;
      frame_cnt_q   <= frame_cnt_d;
      rd_valid_q    <= rd_valid_d;
    end
  end

  img_ram u_ram (
    .clk_i   (CLK),
    .rst_n_i (RST_N),
    .we_i    (accept),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.s_data),
    .re_i    (rd_req),
    .raddr_i (bus.rd_addr),
    .rdata_o (bus.rd_data)
  );

  assign bus.s_ready     = s_ready_q;
  assign bus.frame_ready = frame_ready_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.err_len     = err_len_q;
  assign bus.frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_img_frame_buffer.sv
// -----------------------------------------------------------------------------
// tb_img_frame_buffer
// Self-checking bench for img_frame_buffer. The reference model assembles
// each frame as a queue of pixels and decides accept/discard from its length.
// -----------------------------------------------------------------------------
module tb_img_frame_buffer;
  import nn_pkg::*;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  img_frame_buffer_if bus ();

  img_frame_buffer dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  typedef struct {
    bit rd_en;
    int addr;
    bit exp_valid;
    int exp_data;
  } rd_vec_t;

  int n_vec = 0;
  int n_err = 0;

  int ref_mem [IMG_SIZE];
  int ref_q [$];
  int ref_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference: a frame is kept only if s_last arrives exactly on pixel IMG_SIZE.
  task automatic model_accept(input int pix, input bit last, output int err, output bit done);
    ref_q.push_back(pix);
    err  = 0;
    done = 0;
    if (last || ref_q.size() == IMG_SIZE) begin
      if (last && ref_q.size() == IMG_SIZE) begin
        foreach (ref_q[k]) ref_mem[k] = ref_q[k];
        ref_cnt = (ref_cnt + 1) % 65536;
        done = 1;
      end else begin
        err = 1;
      end
      ref_q.delete();
    end
  endtask

  task automatic send_pixel(input int pix, input bit last, input bit gaps);
    int budget;
    int err;
    bit done;
    bit acc;
    if (gaps && $urandom_range(1, 0) == 1) begin
      bus.s_valid = 1'b0;
      repeat ($urandom_range(3, 1)) begin
        tick();
        check("err_len_idle", {31'd0, bus.err_len}, 32'd0);
      end
    end
    bus.s_valid = 1'b1;
    bus.s_data  = 8'(pix);
    bus.s_last  = last;
    acc = 1'b0;
    budget = 0;
    while (!acc && budget < 20) begin
      acc = bus.s_ready;
      tick();
      budget++;
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    if (!acc) begin
      n_vec++;
      n_err++;
      $display("FAIL s_ready_timeout: no accept within %0d cycles", budget);
    end else begin
      model_accept(pix, last, err, done);
      check("err_len", {31'd0, bus.err_len}, 32'(err));
      if (done) begin
        check("frame_ready", {31'd0, bus.frame_ready}, 32'd1);
        check("s_ready_full", {31'd0, bus.s_ready}, 32'd0);
        check("frame_cnt", {16'd0, bus.frame_cnt}, 32'(ref_cnt));
      end
    end
  endtask

  // mode 0: pixel i = i % 256, mode 1: random pixels
  task automatic send_frame(input int n, input int last_at, input int mode, input bit gaps);
    for (int i = 0; i < n; i++) begin
      send_pixel((mode == 0) ? (i % 256) : int'($urandom_range(255, 0)), (i == last_at), gaps);
    end
  endtask

  task automatic read_all();
    bus.rd_en = 1'b1;
    for (int a = 0; a < IMG_SIZE; a++) begin
      bus.rd_addr = 10'(a);
      tick();
      check("rd_valid_all", {31'd0, bus.rd_valid}, 32'd1);
      check("rd_data_all", {24'd0, bus.rd_data}, 32'(ref_mem[a]));
    end
    bus.rd_en = 1'b0;
    tick();
    check("rd_valid_idle", {31'd0, bus.rd_valid}, 32'd0);
  endtask

  task automatic release_frame();
    bus.frame_done = 1'b1;
    tick();
    bus.frame_done = 1'b0;
    check("frame_ready_rel", {31'd0, bus.frame_ready}, 32'd0);
    check("s_ready_rel", {31'd0, bus.s_ready}, 32'd1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rd_vec_t tbl [10];
    tbl[0] = '{1, 0,    1, 8'h00};
    tbl[1] = '{1, 1,    1, 8'h01};
    tbl[2] = '{1, 783,  1, 8'h0F};
    tbl[3] = '{1, 255,  1, 8'hFF};
    tbl[4] = '{0, 5,    0, 8'hFF};
    tbl[5] = '{1, 800,  1, 8'h00};
    tbl[6] = '{1, 1023, 1, 8'h00};
    tbl[7] = '{1, 128,  1, 8'h80};
    tbl[8] = '{1, 784,  1, 8'h00};
    tbl[9] = '{0, 0,    0, 8'h00};

    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0;
    bus.rd_en = 1'b0; bus.rd_addr = '0; bus.frame_done = 1'b0;

    // Reset values
    repeat (3) tick();
    check("rst_s_ready", {31'd0, bus.s_ready}, 32'd0);
    check("rst_frame_ready", {31'd0, bus.frame_ready}, 32'd0);
    check("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    check("rst_rd_data", {24'd0, bus.rd_data}, 32'd0);
    check("rst_err_len", {31'd0, bus.err_len}, 32'd0);
    check("rst_frame_cnt", {16'd0, bus.frame_cnt}, 32'd0);
    RST_N = 1'b1;
    tick();
    check("s_ready_after_rst", {31'd0, bus.s_ready}, 32'd1);

    // Gap-free ramp frame, then read vectors and backpressure
    send_frame(IMG_SIZE, IMG_SIZE - 1, 0, 1'b0);
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hAA;
    repeat (5) begin
      tick();
      check("s_ready_stall", {31'd0, bus.s_ready}, 32'd0);
    end
    bus.s_valid = 1'b0;
    foreach (tbl[k]) begin
      bus.rd_en   = tbl[k].rd_en;
      bus.rd_addr = 10'(tbl[k].addr);
      tick();
      check("tbl_rd_valid", {31'd0, bus.rd_valid}, 32'(tbl[k].exp_valid));
      check("tbl_rd_data", {24'd0, bus.rd_data}, 32'(tbl[k].exp_data));
    end

    // Read and release in the same cycle
    bus.rd_en = 1'b1; bus.rd_addr = 10'd5; bus.frame_done = 1'b1;
    tick();
    bus.rd_en = 1'b0; bus.frame_done = 1'b0;
    check("done_rd_valid", {31'd0, bus.rd_valid}, 32'd1);
    check("done_rd_data", {24'd0, bus.rd_data}, 32'h05);
    check("done_s_ready", {31'd0, bus.s_ready}, 32'd1);
    check("done_frame_ready", {31'd0, bus.frame_ready}, 32'd0);

    // Reads and frame_done ignored in FILL
    bus.rd_en = 1'b1; bus.rd_addr = 10'd3;
    tick();
    bus.rd_en = 1'b0;
    check("fill_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    check("fill_rd_hold", {24'd0, bus.rd_data}, 32'h05);
    bus.frame_done = 1'b1;
    tick();
    bus.frame_done = 1'b0;
    check("fill_done_ignored", {31'd0, bus.s_ready}, 32'd1);

    // Short frame, then a random frame with gaps
    send_frame(100, 99, 1, 1'b0);
    tick();
    check("short_err_one_cycle", {31'd0, bus.err_len}, 32'd0);
    check("short_frame_ready", {31'd0, bus.frame_ready}, 32'd0);
    check("short_frame_cnt", {16'd0, bus.frame_cnt}, 32'(ref_cnt));
    send_frame(IMG_SIZE, IMG_SIZE - 1, 1, 1'b1);
    read_all();
    release_frame();

    // Long frame; following pixels start a new frame at address 0
    send_frame(IMG_SIZE, -1, 1, 1'b0);
    check("long_frame_ready", {31'd0, bus.frame_ready}, 32'd0);
    send_frame(IMG_SIZE, IMG_SIZE - 1, 1, 1'b0);
    read_all();
    release_frame();

    // Ramp frame with gaps must read back like the gap-free one
    send_frame(IMG_SIZE, IMG_SIZE - 1, 0, 1'b1);
    read_all();
    release_frame();

    // Asynchronous reset mid-frame
    send_frame(400, -1, 1, 1'b1);
    #3;
    RST_N = 1'b0;
    #1;
    check("async_rst_s_ready", {31'd0, bus.s_ready}, 32'd0);
    check("async_rst_frame_ready", {31'd0, bus.frame_ready}, 32'd0);
    check("async_rst_frame_cnt", {16'd0, bus.frame_cnt}, 32'd0);
    ref_q.delete();
    ref_cnt = 0;
    tick();
    RST_N = 1'b1;
    tick();
    send_frame(IMG_SIZE, IMG_SIZE - 1, 0, 1'b1);
    check("post_rst_frame_cnt", {16'd0, bus.frame_cnt}, 32'd1);
    read_all();
    release_frame();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
